// File: rtl/ux607_pwm16_icb_arb.sv
// Two-master round-robin ICB arbiter in front of the PWM16 register port.
// One transaction in flight; responses are routed back only to the issuing master.
`ifndef UX607_PA_SIZE
`define UX607_PA_SIZE 32
`endif

module ux607_pwm16_icb_arb #(
    parameter int ADDR_W = `UX607_PA_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_icb_cmd_valid,
    output logic              m0_icb_cmd_ready,
    input  logic [ADDR_W-1:0] m0_icb_cmd_addr,
    input  logic              m0_icb_cmd_read,
    input  logic [31:0]       m0_icb_cmd_wdata,
    output logic              m0_icb_rsp_valid,
    input  logic              m0_icb_rsp_ready,
    output logic [31:0]       m0_icb_rsp_rdata,

    input  logic              m1_icb_cmd_valid,
    output logic              m1_icb_cmd_ready,
    input  logic [ADDR_W-1:0] m1_icb_cmd_addr,
    input  logic              m1_icb_cmd_read,
    input  logic [31:0]       m1_icb_cmd_wdata,
    output logic              m1_icb_rsp_valid,
    input  logic              m1_icb_rsp_ready,
    output logic [31:0]       m1_icb_rsp_rdata,

    output logic              s_icb_cmd_valid,
    input  logic              s_icb_cmd_ready,
    output logic [ADDR_W-1:0] s_icb_cmd_addr,
    output logic              s_icb_cmd_read,
    output logic [31:0]       s_icb_cmd_wdata,
    input  logic              s_icb_rsp_valid,
    output logic              s_icb_rsp_ready,
    input  logic [31:0]       s_icb_rsp_rdata,

    output logic              arb_busy,
    output logic              arb_gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t state_r;
    logic   gnt_r;
    logic   last_r;
    logic   gnt_c_s;
    logic   sel_s;
    logic   cmd_phase_s;
    logic   sel_valid_s;

    // Round-robin pick: the master that was not served last wins a tie.
    always_comb begin
        gnt_c_s = 1'b0;
        if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            gnt_c_s = ~last_r;
        end else if (m1_icb_cmd_valid) begin
            gnt_c_s = 1'b1;
        end else begin
            gnt_c_s = 1'b0;
        end
    end

    // Grant in use this cycle: live arbitration in IDLE, locked grant elsewhere.
    always_comb begin
        sel_s       = gnt_r;
        cmd_phase_s = 1'b0;
        case (state_r)
            IDLE: begin
                sel_s       = gnt_c_s;
                cmd_phase_s = 1'b1;
            end
            CMD: begin
                sel_s       = gnt_r;
                cmd_phase_s = 1'b1;
            end
            RSP: begin
                sel_s       = gnt_r;
                cmd_phase_s = 1'b0;
            end
            default: begin
                sel_s       = gnt_r;
                cmd_phase_s = 1'b0;
            end
        endcase
        sel_valid_s = sel_s ? m1_icb_cmd_valid : m0_icb_cmd_valid;
    end

    // Command forwarding from the selected master to the slave.
    always_comb begin
        s_icb_cmd_valid  = cmd_phase_s & sel_valid_s;
        s_icb_cmd_addr   = sel_s ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
        s_icb_cmd_read   = sel_s ? m1_icb_cmd_read  : m0_icb_cmd_read;
        s_icb_cmd_wdata  = sel_s ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
        m0_icb_cmd_ready = cmd_phase_s & ~sel_s & m0_icb_cmd_valid & s_icb_cmd_ready;
        m1_icb_cmd_ready = cmd_phase_s &  sel_s & m1_icb_cmd_valid & s_icb_cmd_ready;
    end

    // Response routing; outside RSP a stray slave response is held off.
    always_comb begin
        m0_icb_rsp_rdata = s_icb_rsp_rdata;
        m1_icb_rsp_rdata = s_icb_rsp_rdata;
        if (state_r == RSP) begin
            m0_icb_rsp_valid = ~gnt_r & s_icb_rsp_valid;
            m1_icb_rsp_valid =  gnt_r & s_icb_rsp_valid;
            s_icb_rsp_ready  = gnt_r ? m1_icb_rsp_ready : m0_icb_rsp_ready;
        end else begin
            m0_icb_rsp_valid = 1'b0;
            m1_icb_rsp_valid = 1'b0;
            s_icb_rsp_ready  = 1'b0;
        end
        arb_busy = (state_r != IDLE);
        arb_gnt  = sel_s;
    end

    // Arbiter state, locked grant and last-served tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            gnt_r   <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (s_icb_cmd_valid) begin
                        gnt_r   <= gnt_c_s;
                        state_r <= s_icb_cmd_ready ? RSP : CMD;
                    end
                end
                CMD: begin
                    if (s_icb_cmd_valid && s_icb_cmd_ready) begin
                        state_r <= RSP;
                    end
                end
                RSP: begin
                    if (s_icb_rsp_valid && s_icb_rsp_ready) begin
                        state_r <= IDLE;
                        last_r  <= gnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ux607_pwm16_icb_arb.sv
// Directed self-checking bench for the two-master PWM16 ICB arbiter.
`timescale 1ns/1ps

module tb_ux607_pwm16_icb_arb;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              m0_icb_cmd_valid = 1'b0, m0_icb_cmd_ready;
    logic [ADDR_W-1:0] m0_icb_cmd_addr = '0;
    logic              m0_icb_cmd_read = 1'b0;
    logic [31:0]       m0_icb_cmd_wdata = '0;
    logic              m0_icb_rsp_valid, m0_icb_rsp_ready = 1'b0;
    logic [31:0]       m0_icb_rsp_rdata;
    logic              m1_icb_cmd_valid = 1'b0, m1_icb_cmd_ready;
    logic [ADDR_W-1:0] m1_icb_cmd_addr = '0;
    logic              m1_icb_cmd_read = 1'b0;
    logic [31:0]       m1_icb_cmd_wdata = '0;
    logic              m1_icb_rsp_valid, m1_icb_rsp_ready = 1'b0;
    logic [31:0]       m1_icb_rsp_rdata;
    logic              s_icb_cmd_valid, s_icb_cmd_ready = 1'b0;
    logic [ADDR_W-1:0] s_icb_cmd_addr;
    logic              s_icb_cmd_read;
    logic [31:0]       s_icb_cmd_wdata;
    logic              s_icb_rsp_valid = 1'b0, s_icb_rsp_ready;
    logic [31:0]       s_icb_rsp_rdata = '0;
    logic              arb_busy, arb_gnt;

    int errors = 0;
    int checks = 0;

    ux607_pwm16_icb_arb #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
        .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_rsp_valid(m0_icb_rsp_valid),
        .m0_icb_rsp_ready(m0_icb_rsp_ready), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
        .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
        .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_rsp_valid(m1_icb_rsp_valid),
        .m1_icb_rsp_ready(m1_icb_rsp_ready), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
        .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_rsp_valid(s_icb_rsp_valid),
        .s_icb_rsp_ready(s_icb_rsp_ready), .s_icb_rsp_rdata(s_icb_rsp_rdata),
        .arb_busy(arb_busy), .arb_gnt(arb_gnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_icb_cmd_valid = 1'b0; m1_icb_cmd_valid = 1'b0;
        m0_icb_rsp_ready = 1'b0; m1_icb_rsp_ready = 1'b0;
        s_icb_cmd_ready = 1'b0;  s_icb_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (arb_busy !== 1'b0) begin $display("FAIL reset_busy: got %b exp 0", arb_busy); errors++; end
        checks++;
        if (s_icb_cmd_valid !== 1'b0) begin $display("FAIL reset_s_cmd_valid: got %b exp 0", s_icb_cmd_valid); errors++; end
        checks++;
        if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b00) begin
            $display("FAIL reset_cmd_ready: got %b exp 00", {m0_icb_cmd_ready, m1_icb_cmd_ready}); errors++;
        end
        checks++;
        if ({m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready} !== 3'b000) begin
            $display("FAIL reset_rsp: got %b exp 000", {m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready}); errors++;
        end
        checks++;
    endtask

    task automatic test_single_read();
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h0000_0010; m0_icb_cmd_read = 1'b1;
        s_icb_cmd_ready = 1'b1;
        #1;
        if (s_icb_cmd_valid !== 1'b1 || s_icb_cmd_addr !== 32'h0000_0010 || s_icb_cmd_read !== 1'b1) begin
            $display("FAIL read_cmd_fwd: got v=%b a=%h r=%b exp v=1 a=00000010 r=1", s_icb_cmd_valid, s_icb_cmd_addr, s_icb_cmd_read);
            errors++;
        end
        checks++;
        if (m0_icb_cmd_ready !== 1'b1 || m1_icb_cmd_ready !== 1'b0) begin
            $display("FAIL read_cmd_ready: got m0=%b m1=%b exp m0=1 m1=0", m0_icb_cmd_ready, m1_icb_cmd_ready); errors++;
        end
        checks++;
        step();
        m0_icb_cmd_valid = 1'b0; s_icb_cmd_ready = 1'b0;
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'hDEAD_BEEF; m0_icb_rsp_ready = 1'b1;
        #1;
        if (m0_icb_rsp_valid !== 1'b1 || m0_icb_rsp_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL read_rsp: got v=%b d=%h exp v=1 d=deadbeef", m0_icb_rsp_valid, m0_icb_rsp_rdata); errors++;
        end
        checks++;
        if (m1_icb_rsp_valid !== 1'b0 || s_icb_rsp_ready !== 1'b1) begin
            $display("FAIL read_rsp_route: got m1v=%b srdy=%b exp m1v=0 srdy=1", m1_icb_rsp_valid, s_icb_rsp_ready); errors++;
        end
        checks++;
        step();
        s_icb_rsp_valid = 1'b0; m0_icb_rsp_ready = 1'b0;
        #1;
        if (arb_busy !== 1'b0 || m1_icb_rsp_valid !== 1'b0) begin
            $display("FAIL read_done: got busy=%b m1v=%b exp busy=0 m1v=0", arb_busy, m1_icb_rsp_valid); errors++;
        end
        checks++;
    endtask

    task automatic test_simultaneous();
        logic [3:0] order;
        do_reset();
        order = 4'b1010;
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h0000_0020;
        m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 32'h0000_0024;
        s_icb_cmd_ready = 1'b1; s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'h0000_5A5A;
        m0_icb_rsp_ready = 1'b1; m1_icb_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_g;
            logic [31:0] exp_a;
            exp_g = order[i];
            exp_a = exp_g ? 32'h0000_0024 : 32'h0000_0020;
            #1;
            if (arb_gnt !== exp_g || s_icb_cmd_addr !== exp_a) begin
                $display("FAIL sim_grant%0d: got g=%b a=%h exp g=%b a=%h", i, arb_gnt, s_icb_cmd_addr, exp_g, exp_a); errors++;
            end
            checks++;
            if (m0_icb_cmd_ready !== ~exp_g || m1_icb_cmd_ready !== exp_g) begin
                $display("FAIL sim_ready%0d: got m0=%b m1=%b exp m0=%b m1=%b", i, m0_icb_cmd_ready, m1_icb_cmd_ready, ~exp_g, exp_g);
                errors++;
            end
            checks++;
            step();
            if (m0_icb_rsp_valid !== ~exp_g || m1_icb_rsp_valid !== exp_g) begin
                $display("FAIL sim_rsp%0d: got m0v=%b m1v=%b exp m0v=%b m1v=%b", i, m0_icb_rsp_valid, m1_icb_rsp_valid, ~exp_g, exp_g);
                errors++;
            end
            checks++;
            step();
        end
        clear_inputs();
        step();
    endtask

    task automatic test_slave_backpressure();
        m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 32'h0000_0030;
        m0_icb_cmd_addr = 32'h0000_0034;
        step();
        m0_icb_cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (arb_gnt !== 1'b1 || s_icb_cmd_addr !== 32'h0000_0030 || m0_icb_cmd_ready !== 1'b0 || arb_busy !== 1'b1) begin
                $display("FAIL bp_hold%0d: got g=%b a=%h m0rdy=%b busy=%b exp g=1 a=00000030 m0rdy=0 busy=1",
                         i, arb_gnt, s_icb_cmd_addr, m0_icb_cmd_ready, arb_busy);
                errors++;
            end
            checks++;
            step();
        end
        s_icb_cmd_ready = 1'b1;
        #1;
        if (m1_icb_cmd_ready !== 1'b1 || m0_icb_cmd_ready !== 1'b0) begin
            $display("FAIL bp_accept: got m1=%b m0=%b exp m1=1 m0=0", m1_icb_cmd_ready, m0_icb_cmd_ready); errors++;
        end
        checks++;
        step();
        m1_icb_cmd_valid = 1'b0; s_icb_cmd_ready = 1'b0;
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'h1111_2222; m1_icb_rsp_ready = 1'b1;
        #1;
        if (m1_icb_rsp_valid !== 1'b1 || m1_icb_rsp_rdata !== 32'h1111_2222 || m0_icb_rsp_valid !== 1'b0) begin
            $display("FAIL bp_m1_rsp: got m1v=%b d=%h m0v=%b exp m1v=1 d=11112222 m0v=0", m1_icb_rsp_valid, m1_icb_rsp_rdata, m0_icb_rsp_valid);
            errors++;
        end
        checks++;
        step();
        s_icb_rsp_valid = 1'b0; m1_icb_rsp_ready = 1'b0; s_icb_cmd_ready = 1'b1;
        #1;
        if (arb_gnt !== 1'b0 || s_icb_cmd_addr !== 32'h0000_0034 || m0_icb_cmd_ready !== 1'b1) begin
            $display("FAIL bp_m0_next: got g=%b a=%h m0rdy=%b exp g=0 a=00000034 m0rdy=1", arb_gnt, s_icb_cmd_addr, m0_icb_cmd_ready);
            errors++;
        end
        checks++;
        step();
        m0_icb_cmd_valid = 1'b0; s_icb_cmd_ready = 1'b0; s_icb_rsp_valid = 1'b1; m0_icb_rsp_ready = 1'b1;
        step();
        clear_inputs();
    endtask

    task automatic test_rsp_backpressure();
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h0000_0040; s_icb_cmd_ready = 1'b1;
        step();
        m0_icb_cmd_valid = 1'b0; s_icb_cmd_ready = 1'b0;
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'hCAFE_F00D; m0_icb_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (s_icb_rsp_ready !== 1'b0 || arb_busy !== 1'b1 || m0_icb_rsp_valid !== 1'b1) begin
                $display("FAIL rbp_hold%0d: got srdy=%b busy=%b m0v=%b exp srdy=0 busy=1 m0v=1", i, s_icb_rsp_ready, arb_busy, m0_icb_rsp_valid);
                errors++;
            end
            checks++;
            step();
        end
        m0_icb_rsp_ready = 1'b1;
        #1;
        if (s_icb_rsp_ready !== 1'b1 || m0_icb_rsp_rdata !== 32'hCAFE_F00D) begin
            $display("FAIL rbp_release: got srdy=%b d=%h exp srdy=1 d=cafef00d", s_icb_rsp_ready, m0_icb_rsp_rdata); errors++;
        end
        checks++;
        step();
        clear_inputs();
        #1;
        if (arb_busy !== 1'b0) begin $display("FAIL rbp_idle: got busy=%b exp 0", arb_busy); errors++; end
        checks++;
    endtask

    task automatic test_stray_response();
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'h0BAD_0BAD;
        m0_icb_rsp_ready = 1'b1; m1_icb_rsp_ready = 1'b1;
        #1;
        if ({s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid} !== 3'b000) begin
            $display("FAIL stray_rsp: got %b exp 000", {s_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid}); errors++;
        end
        checks++;
        step();
        #1;
        if (arb_busy !== 1'b0) begin $display("FAIL stray_busy: got busy=%b exp 0", arb_busy); errors++; end
        checks++;
        clear_inputs();
    endtask

    task automatic test_reset_in_rsp();
        m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 32'h0000_0050; s_icb_cmd_ready = 1'b1;
        step();
        m1_icb_cmd_valid = 1'b0; s_icb_cmd_ready = 1'b0;
        #1;
        if (arb_busy !== 1'b1 || arb_gnt !== 1'b1) begin
            $display("FAIL rrst_pre: got busy=%b g=%b exp busy=1 g=1", arb_busy, arb_gnt); errors++;
        end
        checks++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        if (arb_busy !== 1'b0 || dut.gnt_r !== 1'b0 || dut.last_r !== 1'b1) begin
            $display("FAIL rrst_regs: got busy=%b gnt=%b last=%b exp busy=0 gnt=0 last=1", arb_busy, dut.gnt_r, dut.last_r);
            errors++;
        end
        checks++;
        m0_icb_cmd_valid = 1'b1; m1_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h0000_0060;
        #1;
        if (arb_gnt !== 1'b0 || s_icb_cmd_addr !== 32'h0000_0060) begin
            $display("FAIL rrst_grant: got g=%b a=%h exp g=0 a=00000060", arb_gnt, s_icb_cmd_addr); errors++;
        end
        checks++;
        clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_slave_backpressure();
        test_rsp_backpressure();
        test_stray_response();
        test_reset_in_rsp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ux607_pwm16_icb_arb.md
# ux607_pwm16_icb_arb

Two-master ICB arbiter for the PWM16 peripheral's single register port. It sits between two ICB requesters and the slave-side ICB port of the PWM16 top. Typical requesters are the core's peripheral bus and a hardware duty-cycle sequencer. Arbitration is round-robin with one transaction outstanding, and each response is returned only to the master that issued the command.

## Interface
Parameters:
- ADDR_W, default `UX607_PA_SIZE`: ICB address width on all three ports.

Ports:
- clk  in  1  single clock for the block.
- rst_n  in  1  reset; synchronous, active-low.
- m0_icb_cmd_valid / m0_icb_cmd_ready  in / out  1  master 0 command handshake.
- m0_icb_cmd_addr  in  ADDR_W  master 0 address.
- m0_icb_cmd_read  in  1  master 0 read (1) / write (0).
- m0_icb_cmd_wdata  in  32  master 0 write data.
- m0_icb_rsp_valid / m0_icb_rsp_ready  out / in  1  master 0 response handshake.
- m0_icb_rsp_rdata  out  32  master 0 read data.
- m1_icb_* (same set of signals as m0)  master 1 port.
- s_icb_cmd_valid / s_icb_cmd_ready  out / in  1  command handshake to PWM16.
- s_icb_cmd_addr / s_icb_cmd_read / s_icb_cmd_wdata  out  ADDR_W / 1 / 32  forwarded command.
- s_icb_rsp_valid / s_icb_rsp_ready  in / out  1  response handshake from PWM16.
- s_icb_rsp_rdata  in  32  read data from PWM16.
- arb_busy  out  1  high in CMD and RSP states.
- arb_gnt  out  1  index of the current or last granted master.

## Operation
- State register: IDLE, CMD, RSP. Registers gnt (1 bit) and last (1 bit, the last master served).
- Priority: the master != last wins when both request; a lone requester always wins.
- **IDLE**
  - The grant is combinational (gnt_c) from m0/m1_cmd_valid and last.
  - s_cmd_valid = any request; addr, read and wdata are muxed from gnt_c.
  - The granted master's cmd_ready = s_cmd_ready.
  - If the handshake completes → RSP. If a request is pending without handshake → CMD. In both cases gnt <= gnt_c.
- **CMD**: grant locked to gnt, with no re-arbitration (ICB valid must hold). Forward the gnt master only. On s_cmd handshake → RSP.
- **RSP**
  - m[gnt]_rsp_valid = s_rsp_valid and m[gnt]_rsp_rdata = s_rsp_rdata.
  - s_rsp_ready = m[gnt]_rsp_ready.
  - On handshake → IDLE, last <= gnt.
- Non-granted master: cmd_ready = 0 and rsp_valid = 0 at all times.
- Outside RSP: s_rsp_ready = 0 and both m_rsp_valid = 0. A stray s_rsp_valid is held off and never routed.
- arb_gnt = gnt_c in IDLE, otherwise gnt.

## Timing
- Reset values: state = IDLE, gnt = 0, last = 1 (m0 has first priority).
- Reset-time outputs: s_cmd_valid = 0 unless a master requests; all cmd_ready/rsp_valid = 0; s_rsp_ready = 0; arb_busy = 0.
- Command path is combinational in IDLE and CMD, with zero added latency. The response path is combinational in RSP.
- Minimum transaction is 2 cycles: command handshake in cycle N, response accepted in cycle N+1 or later.
- A back-to-back request is granted the cycle after the response handshake, because IDLE arbitrates combinationally.
- Both masters requesting continuously alternate m0, m1, m0, …
- A new request arriving while busy waits; its valid is held by the master and it sees cmd_ready = 0.
- rst_n low mid-transaction: the next edge forces IDLE and discards the in-flight grant. PWM16 shares rst_n and is reset together.
- No timeout: a slave that never responds leaves the block in RSP indefinitely.

## Test plan
- **Single read:** m0 reads addr 0x10 after reset. Required:
  - s_cmd_valid in the same cycle.
  - With slave cmd_ready = 1 and rsp 1 cycle later carrying 0xDEAD_BEEF, m0_rsp_rdata = 0xDEAD_BEEF.
  - m1_rsp_valid stays 0 throughout.
- **Simultaneous requests after reset:** m0 is granted first, then m1. A second simultaneous pair grants m0 again, giving the order m0, m1, m0, m1 with arb_gnt toggling.
- **Slave backpressure:** s_cmd_ready = 0 for 3 cycles while m1 is in CMD and m0 raises valid. Required:
  - The grant stays m1, the address is unchanged and m0_cmd_ready = 0.
  - m0 is served after m1's response.
- **Master response backpressure:** m0_rsp_ready = 0 for 4 cycles. Required: s_rsp_ready = 0 and state stays RSP. The response is delivered once m0_rsp_ready = 1, and state returns to IDLE.
- **Stray response in IDLE:** s_rsp_valid = 1 with no command issued. Required: s_rsp_ready = 0 and both m_rsp_valid = 0.
- **Reset in RSP:** pull rst_n low in RSP for one edge. Required: arb_busy = 0, gnt = 0, last = 1, and the next simultaneous request grants m0.
